// File: rtl/uart_pkg.sv
// Shared UART definitions: register map, STATUS bit positions and receiver FSM states.
// Used by both the wb_uart transmitter and the wb_uart_rx receiver.
package uart_pkg;

   localparam logic [1:0] UART_REG_DATA   = 2'd0;
   localparam logic [1:0] UART_REG_STATUS = 2'd1;

   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_FRAME_ERR = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head output and wrapping pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/wb_uart_rx.sv
// Wishbone-slave UART receiver: 8N1 deserializer feeding a small receive FIFO,
// drained by the CPU through RXDATA and monitored through STATUS.
module wb_uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_wb_cyc,
   input  logic       i_wb_stb,
   input  logic       i_wb_we,
   input  logic [1:0] i_wb_addr,
   input  logic [7:0] i_wb_data,
   output logic       o_wb_ack,
   output logic       o_wb_stall,
   output logic [7:0] o_wb_data,
   input  logic       i_uart_rx
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);

   rx_state_t     state;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          rx_meta;
   logic          rx_sync;
   logic          rx_prev;
   logic          overrun;
   logic          frame_err;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    fifo_dout;
   logic [AW:0]   fifo_count;
   logic [7:0]    status_byte;
   logic          wb_req;
   logic          rd_data;
   logic          wr_status;
   logic          fifo_pop;
   logic          stop_tick;
   logic          fifo_push;
   logic          set_overrun;
   logic          set_frame_err;
   logic          unused_bits;

   assign wb_req        = i_wb_cyc & i_wb_stb;
   assign rd_data       = wb_req & ~i_wb_we & (i_wb_addr == UART_REG_DATA);
   assign wr_status     = wb_req & i_wb_we & (i_wb_addr == UART_REG_STATUS);
   assign fifo_pop      = rd_data & ~fifo_empty;
   assign stop_tick     = (state == STOP) && (cnt == '0);
   assign fifo_push     = stop_tick & rx_sync;
   assign set_overrun   = fifo_push & fifo_full & ~fifo_pop;
   assign set_frame_err = stop_tick & ~rx_sync;
   assign o_wb_stall    = 1'b0;
   assign unused_bits   = ^{i_wb_data[7:4], i_wb_data[1:0], fifo_count};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (shift_reg),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // rx_prev is one extra stage so a start edge is a 1->0 step of the synchronized line
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= i_uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (rx_prev & ~rx_sync) begin
                  cnt   <= HALF_LOAD;
                  state <= START;
               end
            end
            START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rx_sync) begin
                  state <= IDLE;
               end else begin
                  cnt     <= BIT_LOAD;
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  shift_reg <= {rx_sync, shift_reg[7:1]};
                  cnt       <= BIT_LOAD;
                  if (bit_idx == 3'd7) state <= STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end
            end
            STOP: begin
               if (cnt != '0) cnt <= cnt - 1'b1;
               else           state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A set and a clear in the same cycle leave the flag set
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (set_overrun)                                overrun <= 1'b1;
         else if (wr_status & i_wb_data[STAT_OVERRUN])   overrun <= 1'b0;
         if (set_frame_err)                              frame_err <= 1'b1;
         else if (wr_status & i_wb_data[STAT_FRAME_ERR]) frame_err <= 1'b0;
      end
   end

   always_comb begin
      status_byte                 = 8'h00;
      status_byte[STAT_NOT_EMPTY] = ~fifo_empty;
      status_byte[STAT_FULL]      = fifo_full;
      status_byte[STAT_OVERRUN]   = overrun;
      status_byte[STAT_FRAME_ERR] = frame_err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         o_wb_ack  <= 1'b0;
         o_wb_data <= 8'h00;
      end else begin
         o_wb_ack  <= wb_req;
         o_wb_data <= 8'h00;
         if (wb_req & ~i_wb_we) begin
            case (i_wb_addr)
               UART_REG_DATA:   o_wb_data <= fifo_empty ? 8'h00 : fifo_dout;
               UART_REG_STATUS: o_wb_data <= status_byte;
               default:         o_wb_data <= 8'h00;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wb_uart_rx.sv
// Self-checking bench for wb_uart_rx: directed scenarios plus random traffic
// compared against a queue-based model of the receive FIFO and sticky flags.
`timescale 1ns/1ps
module tb_wb_uart_rx;
   import uart_pkg::*;

   localparam int CPB   = 16;
   localparam int DEPTH = 16;
   // Pin driven just after edge 0; two synchronizer flops and the edge-detect flop
   // put the FSM into START at edge 3, so the stop sample lands at 3 + CPB/2 + 9*CPB.
   localparam int STOP_EDGE = 3 + CPB / 2 + 9 * CPB;

   logic       clk = 1'b0;
   logic       reset;
   logic       cyc;
   logic       stb;
   logic       we;
   logic [1:0] addr;
   logic [7:0] wdata;
   logic       ack;
   logic       stall;
   logic [7:0] rdata;
   logic       uart_rx;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] ref_q[$];
   bit         ref_overrun;
   bit         ref_frame_err;

   always #5 clk = ~clk;

   wb_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .i_wb_cyc   (cyc),
      .i_wb_stb   (stb),
      .i_wb_we    (we),
      .i_wb_addr  (addr),
      .i_wb_data  (wdata),
      .o_wb_ack   (ack),
      .o_wb_stall (stall),
      .o_wb_data  (rdata),
      .i_uart_rx  (uart_rx)
   );

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0] ref_status();
      return {4'b0000, ref_frame_err, ref_overrun, (ref_q.size() == DEPTH), (ref_q.size() != 0)};
   endfunction

   function automatic logic [7:0] ref_pop();
      if (ref_q.size() == 0) return 8'h00;
      return ref_q.pop_front();
   endfunction

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wbRead(input logic [1:0] a, input string tag, output logic [7:0] d);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = a;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      checkOutput({tag, " ack"}, 8'(ack), 8'h01);
      d = rdata;
      @(posedge clk); #1;
      checkOutput({tag, " ack drop"}, 8'(ack), 8'h00);
   endtask

   task automatic wbWrite(input logic [1:0] a, input logic [7:0] v, input string tag);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = a; wdata = v;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      checkOutput({tag, " ack"}, 8'(ack), 8'h01);
      if (a == UART_REG_STATUS) begin
         if (v[STAT_OVERRUN])   ref_overrun   = 1'b0;
         if (v[STAT_FRAME_ERR]) ref_frame_err = 1'b0;
      end
   endtask

   task automatic readData(input string tag);
      logic [7:0] d;
      logic [7:0] exp;
      exp = ref_pop();
      wbRead(UART_REG_DATA, tag, d);
      checkOutput(tag, d, exp);
   endtask

   task automatic readStatus(input string tag);
      logic [7:0] d;
      logic [7:0] exp;
      exp = ref_status();
      wbRead(UART_REG_STATUS, tag, d);
      checkOutput(tag, d, exp);
   endtask

   // Drives one 8N1 frame; optionally reads RXDATA on the stop-sample edge or resets mid-frame
   task automatic applyStimulus(input logic [7:0] value, input bit stop_ok,
                                input bit pop_at_stop, input int abort_at);
      logic [9:0] frame;
      logic [7:0] exp_pop;
      frame = {stop_ok, value, 1'b0};
      exp_pop = 8'h00;
      for (int c = 0; c < 10 * CPB; c++) begin
         @(posedge clk); #1;
         if (c == abort_at) begin
            reset = 1'b1;
            uart_rx = 1'b1;
            idleCycles(2);
            reset = 1'b0;
            ref_q.delete();
            ref_overrun = 1'b0;
            ref_frame_err = 1'b0;
            idleCycles(12 * CPB);
            return;
         end
         uart_rx = frame[c / CPB];
         if (pop_at_stop && c == STOP_EDGE - 1) begin
            cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = UART_REG_DATA;
            exp_pop = ref_pop();
         end
         if (pop_at_stop && c == STOP_EDGE) begin
            cyc = 1'b0; stb = 1'b0;
            checkOutput("stop-edge read ack", 8'(ack), 8'h01);
            checkOutput("stop-edge read data", rdata, exp_pop);
         end
      end
      uart_rx = 1'b1;
      if (stop_ok) begin
         if (ref_q.size() < DEPTH) ref_q.push_back(value);
         else                      ref_overrun = 1'b1;
      end else begin
         ref_frame_err = 1'b1;
      end
      idleCycles(2 * CPB);
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] d;
      reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 2'd0; wdata = 8'h00; uart_rx = 1'b1;
      ref_overrun = 1'b0; ref_frame_err = 1'b0;
      idleCycles(3);
      checkOutput("reset ack", 8'(ack), 8'h00);
      checkOutput("reset data", rdata, 8'h00);
      checkOutput("reset stall", 8'(stall), 8'h00);
      reset = 1'b0;
      idleCycles(2);
      readStatus("status after reset");

      applyStimulus(8'hA5, 1'b1, 1'b0, -1);
      readStatus("status A5");
      readData("data A5");
      readStatus("status A5 drained");

      @(posedge clk); #1; uart_rx = 1'b0;
      idleCycles(4);
      uart_rx = 1'b1;
      idleCycles(2 * CPB);
      readStatus("status glitch");
      applyStimulus(8'h5A, 1'b1, 1'b0, -1);
      readData("data after glitch");

      applyStimulus(8'h3C, 1'b0, 1'b0, -1);
      readStatus("status frame err");
      wbWrite(UART_REG_STATUS, 8'h08, "clear frame err");
      readStatus("status frame err cleared");

      for (int i = 0; i <= DEPTH; i++) applyStimulus(8'(i), 1'b1, 1'b0, -1);
      readStatus("status overrun");
      for (int i = 0; i <= DEPTH; i++) readData("drain overrun");
      readStatus("status after drain");
      wbWrite(UART_REG_STATUS, 8'h04, "clear overrun");
      readStatus("status overrun cleared");

      for (int i = 0; i < DEPTH; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1);
      applyStimulus(8'h77, 1'b1, 1'b1, -1);
      readStatus("status push+pop full");
      for (int i = 0; i < DEPTH; i++) readData("drain push+pop");
      readStatus("status push+pop drained");

      applyStimulus(8'h55, 1'b1, 1'b0, 4 * CPB + CPB / 2);
      readStatus("status after mid-frame reset");
      applyStimulus(8'h81, 1'b1, 1'b0, -1);
      readData("data 81 after reset");

      readData("empty data read");
      wbRead(2'd2, "addr2", d);
      checkOutput("addr2 data", d, 8'h00);
      wbWrite(2'd3, 8'hFF, "addr3 write");
      readStatus("status after addr3 write");

      // Two requests on consecutive cycles: STATUS then RXDATA
      applyStimulus(8'hC3, 1'b1, 1'b0, -1);
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = UART_REG_STATUS;
      @(posedge clk); #1;
      checkOutput("b2b ack1", 8'(ack), 8'h01);
      checkOutput("b2b status", rdata, ref_status());
      addr = UART_REG_DATA;
      @(posedge clk); #1;
      cyc = 1'b0; stb = 1'b0;
      checkOutput("b2b ack2", 8'(ack), 8'h01);
      checkOutput("b2b data", rdata, ref_pop());
      @(posedge clk); #1;
      checkOutput("b2b ack drop", 8'(ack), 8'h00);

      for (int i = 0; i < 40; i++) begin
         int op;
         op = int'($urandom_range(0, 9));
         if (op < 5)       applyStimulus(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), 1'b0, -1);
         else if (op < 8)  readData("rand data");
         else if (op == 8) readStatus("rand status");
         else              wbWrite(UART_REG_STATUS, 8'($urandom_range(0, 255)), "rand status write");
      end
      readStatus("final status");
      checkOutput("final stall", 8'(stall), 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/wb_uart_rx.md
# wb_uart_rx

Wishbone-slave UART receiver, the receive-side companion of the SoC's `wb_uart` transmitter. Samples the asynchronous serial input (8N1, LSB first) at a fixed baud rate and buffers complete bytes in a small FIFO. The CPU drains the FIFO over the same single-cycle-ack Wishbone bus used by the other peripherals. It is decoded by the SoC address logic in the 0xc000xxxx I/O window.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per bit (50 MHz / 115200). Minimum 4.
- `FIFO_DEPTH`, 16: receive FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_wb_cyc`  in  1  cycle valid; already qualified by the address decode.
- `i_wb_stb`  in  1  strobe.
- `i_wb_we`  in  1  write enable.
- `i_wb_addr`  in  2  register select.
- `i_wb_data`  in  8  write data.
- `o_wb_ack`  out  1  one-cycle acknowledge.
- `o_wb_stall`  out  1  tied 0.
- `o_wb_data`  out  8  read data; valid while `o_wb_ack` is high.
- `i_uart_rx`  in  1  asynchronous serial input; idles high.

## Operation
- Register map:
  - Addr 0, RXDATA (R): returns the FIFO head and pops it. If the FIFO is empty, returns 0x00 and does not pop. Writes are acked and ignored.
  - Addr 1, STATUS:
    - Read bits: [0] not_empty, [1] full, [2] overrun (sticky), [3] frame_err (sticky), [7:4] 0.
    - Write: a 1 in bit 2 or bit 3 clears that flag; other bits are ignored.
  - Addr 2–3: read 0x00; writes ignored; always acked.
- Input path: `i_uart_rx` passes through a 2-flop synchronizer (reset value 1). A start is a 1→0 transition on the synchronized line.
- FSM states and transitions:
  - IDLE: on a start edge, load the counter and go to START.
  - START: wait HALF = CLKS_PER_BIT/2 (floor) cycles, then sample. If the sample is 1, treat it as a glitch and return to IDLE. If 0, go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 times, shifting LSB first. Then go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles, then return to IDLE.
    - Sample is 1: push the byte. If the FIFO is full and there is no pop in the same cycle, drop the byte and set overrun.
    - Sample is 0: discard the byte and set frame_err.
- FIFO: `FIFO_DEPTH` entries, with a count of log2(FIFO_DEPTH)+1 bits and wrapping pointers.
  - A push and a pop in the same cycle both take effect; the count is unchanged.
  - When full, a push plus a pop in the same cycle succeeds and does not set overrun.
- Flag priority: a set and a clear of the same flag in the same cycle leaves the flag set.
- Reset: state IDLE, FIFO empty, both sticky flags 0, shift register 0, synchronizer 1, `o_wb_ack`=0, `o_wb_data`=0x00, `o_wb_stall`=0. A reset mid-frame abandons the frame with no push and no flag.

## Timing
- Let E be the cycle the synchronized edge is seen (2 cycles after the pin edge).
- Sample points:
  - Start bit: E+HALF.
  - Data bit k (k = 0..7): E+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit: E+HALF+9·CLKS_PER_BIT.
- The FIFO write happens in the stop-sample cycle; STATUS reflects it from the next cycle.
- Wishbone:
  - A request is `i_wb_cyc & i_wb_stb`. `o_wb_ack` rises the following cycle for exactly one cycle.
  - Back-to-back requests ack on consecutive cycles.
  - The pop or flag clear takes effect in the request cycle. `o_wb_data` is registered in that same cycle.
- A new start edge is accepted in the first IDLE cycle after STOP. The line must return high first, since a start requires a 1→0 transition.

## Structure
- Shared package `uart_pkg` holds:
  - Register address constants (`UART_REG_DATA`=0, `UART_REG_STATUS`=1).
  - STATUS bit indices.
  - The receiver FSM state enum (IDLE, START, DATA, STOP).
  - The `wb_uart` TX side also uses this package.
- Sub-module `sync_fifo` (parameters WIDTH=8, DEPTH), with ports push, pop, din, dout (head, combinational), full, empty, count. It is reusable for a future TX FIFO.

## Test plan
(Simulate with CLKS_PER_BIT=16.)
- Receive byte: drive 0xA5 as 8N1 → STATUS reads 0x01; RXDATA reads 0xA5 with ack one cycle after stb; STATUS then reads 0x00.
- Glitch rejection: a 4-cycle low pulse on `i_uart_rx` → no push, flags stay 0, FSM back in IDLE.
- Frame error: send 0x3C with the stop bit low → FIFO stays empty, STATUS=0x08. Writing 0x08 to STATUS → STATUS=0x00.
- Full FIFO and overrun:
  - Send 17 bytes 0x00..0x10 with no reads → STATUS=0x07 (not_empty, full, overrun).
  - Then 16 reads return 0x00..0x0F in order; a 17th read returns 0x00 with STATUS=0x04.
- Simultaneous push and pop: with the FIFO full, issue an RXDATA read in the exact stop-sample cycle of an incoming 0x77 → no overrun, count stays 16, and the last entry drained is 0x77.
- Reset mid-frame: assert `reset` during data bit 3 of 0x55 → FIFO empty, STATUS=0x00. A following byte 0x81 is received correctly.
